// File: rtl/rggen_bit_field_ext_if.sv
// Register-access bus between a register block and one bit field.
// The register block drives the access strobes; the field returns its value.
interface rggen_bit_field_ext_if #(
  parameter int WIDTH = 1
);
  logic             write_access;
  logic             read_access;
  logic [WIDTH-1:0] write_data;
  logic [WIDTH-1:0] write_mask;
  logic [WIDTH-1:0] read_data;
  logic [WIDTH-1:0] value;

  modport master (
    output write_access, read_access, write_data, write_mask,
    input  read_data, value
  );

  modport slave (
    input  write_access, read_access, write_data, write_mask,
    output read_data, value
  );
endinterface

// File: rtl/rggen_bit_field_ext.sv
// Single register bit field with selectable software access mode (RW/W1C/W1S/RC/RWO)
// and hardware load, set and clear ports layered on top of the software effect.
module rggen_bit_field_ext #(
  parameter int               WIDTH         = 1,
  parameter logic [WIDTH-1:0] INITIAL_VALUE = '0,
  parameter int               MODE          = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  rggen_bit_field_ext_if.slave        bit_field_if,
  input  logic                        i_hw_write_enable,
  input  logic [WIDTH-1:0]            i_hw_write_data,
  input  logic [WIDTH-1:0]            i_hw_set,
  input  logic [WIDTH-1:0]            i_hw_clear,
  output logic [WIDTH-1:0]            o_value,
  output logic                        o_write_trigger,
  output logic                        o_read_trigger,
  output logic                        o_locked
);

  localparam int ModeRw  = 0;
  localparam int ModeW1c = 1;
  localparam int ModeW1s = 2;
  localparam int ModeRc  = 3;
  localparam int ModeRwo = 4;

  if (MODE < ModeRw || MODE > ModeRwo) begin : g_bad_mode
    $fatal(1, "rggen_bit_field_ext: unsupported MODE %0d", MODE);
  end
  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $fatal(1, "rggen_bit_field_ext: unsupported WIDTH %0d", WIDTH);
  end

  logic             write_access;
  logic             read_access;
  logic [WIDTH-1:0] write_data;
  logic [WIDTH-1:0] write_mask;

  assign write_access = bit_field_if.write_access;
  assign read_access  = bit_field_if.read_access;
  assign write_data   = bit_field_if.write_data;
  assign write_mask   = bit_field_if.write_mask;

  logic [WIDTH-1:0] value_q, value_d, sw_value;
  logic             locked_q, locked_d;
  logic             write_hit;
  logic             sw_write_ok;
  logic             write_trigger_q;
  logic             read_trigger_q;

  always_comb begin
    write_hit   = write_access && (|write_mask);
    sw_value    = value_q;
    sw_write_ok = 1'b0;
    locked_d    = locked_q;
    case (MODE)
      ModeRw: begin
        if (write_access) sw_value = (value_q & ~write_mask) | (write_data & write_mask);
        sw_write_ok = write_hit;
      end
      ModeW1c: begin
        if (write_access) sw_value = value_q & ~(write_mask & write_data);
        sw_write_ok = write_hit;
      end
      ModeW1s: begin
        if (write_access) sw_value = value_q | (write_mask & write_data);
        sw_write_ok = write_hit;
      end
      ModeRc: begin
        // Writes are ignored; a read clears the whole field.
        if (read_access) sw_value = '0;
      end
      ModeRwo: begin
        if (write_hit && !locked_q) begin
          sw_value    = (value_q & ~write_mask) | (write_data & write_mask);
          sw_write_ok = 1'b1;
          locked_d    = 1'b1;
        end
      end
      default: ;
    endcase

    // Hardware overrides software; set is applied last so it wins over clear.
    value_d = sw_value;
    if (i_hw_write_enable) value_d = i_hw_write_data;
    value_d = (value_d & ~i_hw_clear) | i_hw_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q         <= INITIAL_VALUE;
      locked_q        <= 1'b0;
      write_trigger_q <= 1'b0;
      read_trigger_q  <= 1'b0;
    end else begin
      value_q         <= value_d;
      locked_q        <= locked_d;
      write_trigger_q <= sw_write_ok;
      read_trigger_q  <= read_access;
    end
  end

  assign o_value                = value_q;
  assign bit_field_if.value     = value_q;
  assign bit_field_if.read_data = value_q;
  assign o_write_trigger        = write_trigger_q;
  assign o_read_trigger         = read_trigger_q;
  assign o_locked               = (MODE == ModeRwo) ? locked_q : 1'b0;

endmodule

// File: tb/tb_rggen_bit_field_ext.sv
// Directed bench: one field instance per access mode, each scenario checked in its own task.
module tb_rggen_bit_field_ext;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // RW, WIDTH=8, init 0x5A
  rggen_bit_field_ext_if #(.WIDTH(8)) if_rw ();
  logic       rw_hwe;
  logic [7:0] rw_hwd, rw_set, rw_clr, rw_val;
  logic       rw_wt, rw_rt, rw_lk;
  rggen_bit_field_ext #(.WIDTH(8), .INITIAL_VALUE(8'h5A), .MODE(0)) u_rw (
    .clk(clk), .rst(rst), .bit_field_if(if_rw),
    .i_hw_write_enable(rw_hwe), .i_hw_write_data(rw_hwd), .i_hw_set(rw_set),
    .i_hw_clear(rw_clr), .o_value(rw_val), .o_write_trigger(rw_wt),
    .o_read_trigger(rw_rt), .o_locked(rw_lk)
  );

  // W1C, WIDTH=8, init 0xF0
  rggen_bit_field_ext_if #(.WIDTH(8)) if_wc ();
  logic       wc_hwe;
  logic [7:0] wc_hwd, wc_set, wc_clr, wc_val;
  logic       wc_wt, wc_rt, wc_lk;
  rggen_bit_field_ext #(.WIDTH(8), .INITIAL_VALUE(8'hF0), .MODE(1)) u_wc (
    .clk(clk), .rst(rst), .bit_field_if(if_wc),
    .i_hw_write_enable(wc_hwe), .i_hw_write_data(wc_hwd), .i_hw_set(wc_set),
    .i_hw_clear(wc_clr), .o_value(wc_val), .o_write_trigger(wc_wt),
    .o_read_trigger(wc_rt), .o_locked(wc_lk)
  );

  // RC, WIDTH=4, init 0xA
  rggen_bit_field_ext_if #(.WIDTH(4)) if_rc ();
  logic       rc_hwe;
  logic [3:0] rc_hwd, rc_set, rc_clr, rc_val;
  logic       rc_wt, rc_rt, rc_lk;
  rggen_bit_field_ext #(.WIDTH(4), .INITIAL_VALUE(4'hA), .MODE(3)) u_rc (
    .clk(clk), .rst(rst), .bit_field_if(if_rc),
    .i_hw_write_enable(rc_hwe), .i_hw_write_data(rc_hwd), .i_hw_set(rc_set),
    .i_hw_clear(rc_clr), .o_value(rc_val), .o_write_trigger(rc_wt),
    .o_read_trigger(rc_rt), .o_locked(rc_lk)
  );

  // RWO, WIDTH=8, init 0x00
  rggen_bit_field_ext_if #(.WIDTH(8)) if_wo ();
  logic       wo_hwe;
  logic [7:0] wo_hwd, wo_set, wo_clr, wo_val;
  logic       wo_wt, wo_rt, wo_lk;
  rggen_bit_field_ext #(.WIDTH(8), .INITIAL_VALUE(8'h00), .MODE(4)) u_wo (
    .clk(clk), .rst(rst), .bit_field_if(if_wo),
    .i_hw_write_enable(wo_hwe), .i_hw_write_data(wo_hwd), .i_hw_set(wo_set),
    .i_hw_clear(wo_clr), .o_value(wo_val), .o_write_trigger(wo_wt),
    .o_read_trigger(wo_rt), .o_locked(wo_lk)
  );

  // W1S, WIDTH=64, init 0
  rggen_bit_field_ext_if #(.WIDTH(64)) if_ws ();
  logic        ws_hwe;
  logic [63:0] ws_hwd, ws_set, ws_clr, ws_val;
  logic        ws_wt, ws_rt, ws_lk;
  rggen_bit_field_ext #(.WIDTH(64), .INITIAL_VALUE(64'h0), .MODE(2)) u_ws (
    .clk(clk), .rst(rst), .bit_field_if(if_ws),
    .i_hw_write_enable(ws_hwe), .i_hw_write_data(ws_hwd), .i_hw_set(ws_set),
    .i_hw_clear(ws_clr), .o_value(ws_val), .o_write_trigger(ws_wt),
    .o_read_trigger(ws_rt), .o_locked(ws_lk)
  );

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_all();
    if_rw.write_access = 0; if_rw.read_access = 0; if_rw.write_data = '0; if_rw.write_mask = '0;
    if_wc.write_access = 0; if_wc.read_access = 0; if_wc.write_data = '0; if_wc.write_mask = '0;
    if_rc.write_access = 0; if_rc.read_access = 0; if_rc.write_data = '0; if_rc.write_mask = '0;
    if_wo.write_access = 0; if_wo.read_access = 0; if_wo.write_data = '0; if_wo.write_mask = '0;
    if_ws.write_access = 0; if_ws.read_access = 0; if_ws.write_data = '0; if_ws.write_mask = '0;
    rw_hwe = 0; rw_hwd = '0; rw_set = '0; rw_clr = '0;
    wc_hwe = 0; wc_hwd = '0; wc_set = '0; wc_clr = '0;
    rc_hwe = 0; rc_hwd = '0; rc_set = '0; rc_clr = '0;
    wo_hwe = 0; wo_hwd = '0; wo_set = '0; wo_clr = '0;
    ws_hwe = 0; ws_hwd = '0; ws_set = '0; ws_clr = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (rw_val !== 8'h5A) begin failures++;
      $display("FAIL reset_rw_value got=%h exp=5a", rw_val); end
    checks++; if (wc_val !== 8'hF0) begin failures++;
      $display("FAIL reset_w1c_value got=%h exp=f0", wc_val); end
    checks++; if (rc_val !== 4'hA) begin failures++;
      $display("FAIL reset_rc_value got=%h exp=a", rc_val); end
    checks++; if (ws_val !== 64'h0) begin failures++;
      $display("FAIL reset_w1s_value got=%h exp=0", ws_val); end
    checks++; if ({wo_val, wo_lk} !== 9'h0) begin failures++;
      $display("FAIL reset_rwo got=%h/%b exp=00/0", wo_val, wo_lk); end
    checks++; if ({rw_wt, rw_rt, rc_wt, rc_rt} !== 4'b0000) begin failures++;
      $display("FAIL reset_triggers got=%b exp=0000", {rw_wt, rw_rt, rc_wt, rc_rt}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_rw();
    if_rw.write_access = 1; if_rw.write_data = 8'hFF; if_rw.write_mask = 8'h0F;
    tick();
    idle_all();
    checks++; if (rw_val !== 8'h5F) begin failures++;
      $display("FAIL rw_write_value got=%h exp=5f", rw_val); end
    checks++; if (rw_wt !== 1'b1) begin failures++;
      $display("FAIL rw_write_trigger got=%b exp=1", rw_wt); end
    checks++; if (if_rw.read_data !== 8'h5F || if_rw.value !== 8'h5F) begin failures++;
      $display("FAIL rw_if_value got=%h/%h exp=5f", if_rw.read_data, if_rw.value); end
    checks++; if (rw_lk !== 1'b0) begin failures++;
      $display("FAIL rw_locked got=%b exp=0", rw_lk); end
    tick();
    checks++; if (rw_wt !== 1'b0) begin failures++;
      $display("FAIL rw_trigger_single got=%b exp=0", rw_wt); end
    // Zero-mask write: no change, no pulse.
    if_rw.write_access = 1; if_rw.write_data = 8'h00; if_rw.write_mask = 8'h00;
    tick();
    idle_all();
    checks++; if (rw_val !== 8'h5F || rw_wt !== 1'b0) begin failures++;
      $display("FAIL rw_zero_mask got=%h/%b exp=5f/0", rw_val, rw_wt); end
  endtask

  task automatic test_w1c();
    if_wc.write_access = 1; if_wc.write_data = 8'h30; if_wc.write_mask = 8'hFF;
    wc_set = 8'h10;
    tick();
    idle_all();
    checks++; if (wc_val !== 8'hD0) begin failures++;
      $display("FAIL w1c_with_set got=%h exp=d0", wc_val); end
    checks++; if (wc_wt !== 1'b1) begin failures++;
      $display("FAIL w1c_trigger got=%b exp=1", wc_wt); end
    // Set wins over clear.
    wc_clr = 8'hFF; wc_set = 8'h01;
    tick();
    idle_all();
    checks++; if (wc_val !== 8'h01) begin failures++;
      $display("FAIL w1c_set_over_clear got=%h exp=01", wc_val); end
    // Hardware load wins over a software write in the same cycle.
    if_wc.write_access = 1; if_wc.write_data = 8'hFF; if_wc.write_mask = 8'hFF;
    wc_hwe = 1; wc_hwd = 8'h3C;
    tick();
    idle_all();
    checks++; if (wc_val !== 8'h3C) begin failures++;
      $display("FAIL w1c_hw_over_sw got=%h exp=3c", wc_val); end
  endtask

  task automatic test_rc();
    if_rc.read_access = 1;
    #1;
    checks++; if (if_rc.read_data !== 4'hA) begin failures++;
      $display("FAIL rc_read_data got=%h exp=a", if_rc.read_data); end
    tick();
    idle_all();
    checks++; if (rc_val !== 4'h0) begin failures++;
      $display("FAIL rc_clear got=%h exp=0", rc_val); end
    checks++; if (rc_rt !== 1'b1) begin failures++;
      $display("FAIL rc_read_trigger got=%b exp=1", rc_rt); end
    // Writes in RC mode have no effect and no trigger.
    if_rc.write_access = 1; if_rc.write_data = 4'hF; if_rc.write_mask = 4'hF;
    tick();
    idle_all();
    checks++; if (rc_val !== 4'h0 || rc_wt !== 1'b0 || rc_rt !== 1'b0) begin failures++;
      $display("FAIL rc_write_ignored got=%h/%b/%b exp=0/0/0", rc_val, rc_wt, rc_rt); end
    rc_hwe = 1; rc_hwd = 4'hF;
    tick();
    idle_all();
    checks++; if (rc_val !== 4'hF) begin failures++;
      $display("FAIL rc_hw_load got=%h exp=f", rc_val); end
    if_rc.read_access = 1; rc_set = 4'h1;
    #1;
    checks++; if (if_rc.read_data !== 4'hF) begin failures++;
      $display("FAIL rc_read_pre_update got=%h exp=f", if_rc.read_data); end
    tick();
    idle_all();
    checks++; if (rc_val !== 4'h1) begin failures++;
      $display("FAIL rc_read_with_set got=%h exp=1", rc_val); end
  endtask

  task automatic test_back_to_back();
    if_rc.read_access = 1;
    tick();
    checks++; if (rc_rt !== 1'b1) begin failures++;
      $display("FAIL b2b_read_first got=%b exp=1", rc_rt); end
    tick();
    idle_all();
    checks++; if (rc_rt !== 1'b1) begin failures++;
      $display("FAIL b2b_read_second got=%b exp=1", rc_rt); end
    tick();
    checks++; if (rc_rt !== 1'b0) begin failures++;
      $display("FAIL b2b_read_end got=%b exp=0", rc_rt); end
  endtask

  task automatic test_rwo();
    if_wo.write_access = 1; if_wo.write_data = 8'h55; if_wo.write_mask = 8'h00;
    tick();
    idle_all();
    checks++; if ({wo_val, wo_lk, wo_wt} !== {8'h00, 2'b00}) begin failures++;
      $display("FAIL rwo_zero_mask got=%h/%b/%b exp=00/0/0", wo_val, wo_lk, wo_wt); end
    if_wo.write_access = 1; if_wo.write_data = 8'h12; if_wo.write_mask = 8'hFF;
    tick();
    idle_all();
    checks++; if ({wo_val, wo_lk, wo_wt} !== {8'h12, 2'b11}) begin failures++;
      $display("FAIL rwo_first_write got=%h/%b/%b exp=12/1/1", wo_val, wo_lk, wo_wt); end
    if_wo.write_access = 1; if_wo.write_data = 8'h34; if_wo.write_mask = 8'hFF;
    tick();
    idle_all();
    checks++; if ({wo_val, wo_lk, wo_wt} !== {8'h12, 2'b10}) begin failures++;
      $display("FAIL rwo_locked_write got=%h/%b/%b exp=12/1/0", wo_val, wo_lk, wo_wt); end
    wo_hwe = 1; wo_hwd = 8'h77;
    tick();
    idle_all();
    checks++; if (wo_val !== 8'h77 || wo_lk !== 1'b1) begin failures++;
      $display("FAIL rwo_hw_load got=%h/%b exp=77/1", wo_val, wo_lk); end
  endtask

  task automatic test_w1s64();
    if_ws.write_access = 1; if_ws.write_data = 64'h8000_0000_0000_0001;
    if_ws.write_mask = {64{1'b1}};
    tick();
    idle_all();
    checks++; if (ws_val !== 64'h8000_0000_0000_0001 || ws_wt !== 1'b1) begin failures++;
      $display("FAIL w1s64_set got=%h/%b exp=8000000000000001/1", ws_val, ws_wt); end
    ws_clr = 64'h1;
    tick();
    idle_all();
    checks++; if (ws_val !== 64'h8000_0000_0000_0000) begin failures++;
      $display("FAIL w1s64_clear got=%h exp=8000000000000000", ws_val); end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    if_rw.write_access = 1; if_rw.write_data = 8'h00; if_rw.write_mask = 8'hFF; rw_set = 8'h01;
    if_wo.write_access = 1; if_wo.write_data = 8'h99; if_wo.write_mask = 8'hFF; wo_set = 8'h80;
    if_rc.read_access = 1;
    tick();
    rst = 1'b0;
    idle_all();
    checks++; if (rw_val !== 8'h5A || rw_wt !== 1'b0) begin failures++;
      $display("FAIL rst_mid_rw got=%h/%b exp=5a/0", rw_val, rw_wt); end
    checks++; if ({wo_val, wo_lk, wo_wt} !== {8'h00, 2'b00}) begin failures++;
      $display("FAIL rst_mid_rwo got=%h/%b/%b exp=00/0/0", wo_val, wo_lk, wo_wt); end
    checks++; if (rc_val !== 4'hA || rc_rt !== 1'b0) begin failures++;
      $display("FAIL rst_mid_rc got=%h/%b exp=a/0", rc_val, rc_rt); end
    tick();
    checks++; if ({rw_wt, wo_wt, rc_rt} !== 3'b000) begin failures++;
      $display("FAIL rst_mid_no_pulse got=%b exp=000", {rw_wt, wo_wt, rc_rt}); end
    // Lock is released by reset, so a new write is accepted.
    if_wo.write_access = 1; if_wo.write_data = 8'hA5; if_wo.write_mask = 8'hFF;
    tick();
    idle_all();
    checks++; if ({wo_val, wo_lk, wo_wt} !== {8'hA5, 2'b11}) begin failures++;
      $display("FAIL rst_rwo_relock got=%h/%b/%b exp=a5/1/1", wo_val, wo_lk, wo_wt); end
  endtask

  initial begin
    idle_all();
    test_reset();
    test_rw();
    test_w1c();
    test_rc();
    test_back_to_back();
    test_rwo();
    test_w1s64();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rggen_bit_field_ext.md
RGGEN_BIT_FIELD_EXT -- requirements
Module: rggen_bit_field_ext

Interface
REQ-001 SHALL provide parameter WIDTH, default 1: bit-field width in bits, legal range 1..64.
REQ-002 SHALL provide parameter INITIAL_VALUE, default '0: WIDTH-bit value loaded on reset.
REQ-003 SHALL provide parameter MODE, default 0: access behaviour; 0 RW, 1 W1C, 2 W1S, 3 RC (read-clear), 4 RWO (write-once); any other value is a fatal elaboration error.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-006 bit_field_if  interface port (slave)  -  register access bus; members write_access, read_access, write_data[WIDTH], write_mask[WIDTH], read_data[WIDTH], value[WIDTH].
REQ-007 i_hw_write_enable  input  1  hardware load strobe.
REQ-008 i_hw_write_data  input  WIDTH  hardware load data.
REQ-009 i_hw_set  input  WIDTH  per-bit hardware set.
REQ-010 i_hw_clear  input  WIDTH  per-bit hardware clear.
REQ-011 o_value  output  WIDTH  current field value.
REQ-012 o_write_trigger  output  1  one-cycle pulse after an effective software write.
REQ-013 o_read_trigger  output  1  one-cycle pulse after a software read.
REQ-014 o_locked  output  1  write-once lock status; constant 0 when MODE != 4.

Function
REQ-015 value SHALL be a WIDTH-bit register; o_value, bit_field_if.value and bit_field_if.read_data SHALL all equal value combinationally.
REQ-016 Software effect S, per bit, with m = write_mask and d = write_data:
- RW: S = (value & ~m) | (d & m) when write_access.
- W1C: bit cleared where write_access & m & d.
- W1S: bit set where write_access & m & d.
- RC: S = 0 when read_access; writes have no effect.
- RWO: as RW only when write_access & |m & !locked, else value held.
REQ-017 Next-value order, evaluated every cycle: start from S (or value if no access); if i_hw_write_enable, replace with i_hw_write_data; then clear bits in i_hw_clear; then set bits in i_hw_set. Set SHALL win over clear, and hardware over software.
REQ-018 An RC read coinciding with i_hw_set SHALL leave the set bits at 1; read_data in that cycle SHALL be the pre-update value.
REQ-019 All value updates SHALL take effect on the rising edge after the access cycle, giving 1-cycle latency to o_value.
REQ-020 RWO lock: a 1-bit register SHALL be set by the first write_access with |write_mask = 1, and held until reset. Hardware inputs SHALL still modify value while locked. A write with write_mask = 0 SHALL NOT lock.
REQ-021 o_write_trigger SHALL be registered and assert for exactly one cycle after any write_access cycle with |write_mask = 1 that the mode accepts. It SHALL NOT assert for RC-mode writes or locked RWO writes.
REQ-022 o_read_trigger SHALL be registered and assert for exactly one cycle after each read_access cycle. Back-to-back accesses SHALL produce back-to-back pulses.
REQ-023 Simultaneous write_access and read_access SHALL apply both effects. In RC mode the read clear applies.

Reset
REQ-024 When rst = 1 at a rising edge, the following SHALL hold on the next cycle, regardless of other inputs: value = INITIAL_VALUE, locked = 0, o_write_trigger = 0, o_read_trigger = 0.
REQ-025 Reset asserted mid-operation SHALL discard the pending access; a pulse due that cycle SHALL NOT appear.
REQ-026 No output SHALL depend on rst combinationally.

Verification
REQ-027 RW, WIDTH=8, INITIAL_VALUE=0x5A: write d=0xFF m=0x0F -> o_value 0x5F next cycle, one o_write_trigger pulse.
REQ-028 W1C, WIDTH=8, value=0xF0: write d=0x30 m=0xFF with i_hw_set=0x10 in the same cycle -> o_value 0xD0.
REQ-029 RC, WIDTH=4, value=0xA: read -> read_data 0xA that cycle, o_value 0x0 next cycle, one o_read_trigger pulse. Read with i_hw_set=0x1 -> o_value 0x1.
REQ-030 RWO, WIDTH=8: write 0x12 m=0xFF -> value 0x12, o_locked=1. Second write 0x34 -> value stays 0x12, no trigger. i_hw_write_enable with 0x77 -> 0x77.
REQ-031 Any mode: rst=1 for one cycle during a write plus i_hw_set -> value = INITIAL_VALUE, o_locked=0, no trigger pulse.
REQ-032 WIDTH=64, W1S: write d=0x8000_0000_0000_0001 m=all ones from 0 -> bits 63 and 0 set. i_hw_clear=0x1 -> bit 0 clears, bit 63 unchanged.
